// File: rtl/mctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit.
// Optional exception support is selected with the MCTRL_EXCEPTION_EN macro,
// which adds the EXC state.
package mctrl_pkg;

`ifdef MCTRL_EXCEPTION_EN
  typedef enum logic [2:0] {
    ST_INIT   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_EXC    = 3'd6
  } state_e;
`else
  typedef enum logic [2:0] {
    ST_INIT   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5
  } state_e;
`endif

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_R     = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_SLTIU = 6'h0b;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  // Funct codes (IR[5:0]) for R-type
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;

  // ALUOp[2:0] classes; ALUOp[3] carries OpCode[0]
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_BEQ = 3'b001;
  localparam logic [2:0] ALU_R   = 3'b010;
  localparam logic [2:0] ALU_AND = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // Datapath mux selects
  localparam logic [1:0] REGDST_RD    = 2'b00;
  localparam logic [1:0] REGDST_RT    = 2'b01;
  localparam logic [1:0] REGDST_RA    = 2'b10;
  localparam logic [1:0] WBSEL_ALU    = 2'b00;
  localparam logic [1:0] WBSEL_MDR    = 2'b01;
  localparam logic [1:0] WBSEL_PC     = 2'b10;
  localparam logic [1:0] SRCB_RT      = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMMSH   = 2'b11;
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_JUMP   = 2'b01;
  localparam logic [1:0] PCSRC_RS     = 2'b10;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b11;

  // Exception cause codes
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_BUS     = 2'b10;

endpackage

// File: rtl/mctrl_decode.sv
// Combinational opcode/funct classifier for the multicycle control FSM.
module mctrl_decode
  import mctrl_pkg::*;
(
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  output logic       is_jump_o,
  output logic       is_branch_o,
  output logic       is_load_o,
  output logic       is_store_o,
  output logic       is_rtype_o,
  output logic       is_imm_o,
  output logic       is_shift_o,
  output logic       illegal_o,
  output logic [3:0] alu_op_o
);

  logic [2:0] alu_cls_s;

  // Classify the instruction and pick its ALU operation class
  always_comb begin
    is_jump_o   = 1'b0;
    is_branch_o = 1'b0;
    is_load_o   = 1'b0;
    is_store_o  = 1'b0;
    is_rtype_o  = 1'b0;
    is_imm_o    = 1'b0;
    is_shift_o  = 1'b0;
    illegal_o   = 1'b0;
    alu_cls_s   = ALU_ADD;
    case (opcode_i)
      OP_R: begin
        alu_cls_s = ALU_R;
        if ((funct_i == FN_JR) || (funct_i == FN_JALR)) begin
          is_jump_o = 1'b1;
        end else begin
          is_rtype_o = 1'b1;
          is_shift_o = (funct_i == FN_SLL) || (funct_i == FN_SRL) ||
                       (funct_i == FN_SRA);
        end
      end
      OP_J, OP_JAL:                 is_jump_o   = 1'b1;
      OP_BEQ: begin
        is_branch_o = 1'b1;
        alu_cls_s   = ALU_BEQ;
      end
      OP_ADDI, OP_ADDIU, OP_LUI:    is_imm_o    = 1'b1;
      OP_SLTI, OP_SLTIU: begin
        is_imm_o  = 1'b1;
        alu_cls_s = ALU_SLT;
      end
      OP_ANDI: begin
        is_imm_o  = 1'b1;
        alu_cls_s = ALU_AND;
      end
      OP_LW:                        is_load_o   = 1'b1;
      OP_SW:                        is_store_o  = 1'b1;
      default:                      illegal_o   = 1'b1;
    endcase
    alu_op_o = {opcode_i[0], alu_cls_s};
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control unit: FETCH/DECODE/EXEC/MEM/WB sequencer with a
// memory ready handshake, access timeout, retire pulse and cycle counter.
// Defining MCTRL_EXCEPTION_EN adds the EXC state and the exc_cause output.
module multicycle_control
  import mctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       OpCode,
  input  logic [5:0]       Funct,
  input  logic             Zero,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             IRWrite,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             RegWrite,
  output logic [1:0]       RegDst,
  output logic [1:0]       MemtoReg,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       PCSrc,
  output logic             ExtOp,
  output logic             LuOp,
  output logic [3:0]       ALUOp,
  output logic             instr_done,
  output logic             bus_err,
  output logic [CNT_W-1:0] cyc_cnt,
`ifdef MCTRL_EXCEPTION_EN
  output logic [1:0]       exc_cause,
`endif
  output logic [2:0]       state
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 2);
  localparam logic [WAIT_W-1:0] WAIT_LAST =
    WAIT_W'((MEM_TIMEOUT > 0) ? (MEM_TIMEOUT - 1) : 0);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

`ifdef MCTRL_EXCEPTION_EN
  localparam state_e ST_ABORT = ST_EXC;
`else
  localparam state_e ST_ABORT = ST_FETCH;
`endif

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]  cyc_q, cyc_d;
  logic              timeout_s;

  logic is_jump_s, is_branch_s, is_load_s, is_store_s;
  logic is_rtype_s, is_imm_s, is_shift_s, illegal_s;
  logic [3:0] alu_op_s;

  mctrl_decode u_decode (
    .opcode_i    (OpCode),
    .funct_i     (Funct),
    .is_jump_o   (is_jump_s),
    .is_branch_o (is_branch_s),
    .is_load_o   (is_load_s),
    .is_store_o  (is_store_s),
    .is_rtype_o  (is_rtype_s),
    .is_imm_o    (is_imm_s),
    .is_shift_o  (is_shift_s),
    .illegal_o   (illegal_s),
    .alu_op_o    (alu_op_s)
  );

  // A completing access on the last allowed cycle wins over the timeout
  assign timeout_s = (MEM_TIMEOUT != 0) && (wait_q == WAIT_LAST) && !mem_ready;

`ifdef MCTRL_EXCEPTION_EN
  logic [1:0] exc_q, exc_d;
  assign exc_cause = exc_q;
`endif

  // Next-state and Moore datapath controls for the current state
  always_comb begin
    state_d    = state_q;
    PCWrite    = 1'b0;
    IRWrite    = 1'b0;
    IorD       = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    RegWrite   = 1'b0;
    RegDst     = REGDST_RD;
    MemtoReg   = WBSEL_ALU;
    ALUSrcA    = 1'b0;
    ALUSrcB    = SRCB_RT;
    PCSrc      = PCSRC_ALU;
    ExtOp      = 1'b0;
    LuOp       = 1'b0;
    ALUOp      = 4'b0000;
    instr_done = 1'b0;
    bus_err    = 1'b0;
`ifdef MCTRL_EXCEPTION_EN
    exc_d      = exc_q;
`endif
    case (state_q)
      ST_INIT: state_d = ST_FETCH;
      ST_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = SRCB_FOUR;
        PCWrite = mem_ready;
        IRWrite = mem_ready;
        if (mem_ready) begin
          state_d = ST_DECODE;
        end else if (timeout_s) begin
          bus_err = 1'b1;
          state_d = ST_ABORT;
`ifdef MCTRL_EXCEPTION_EN
          exc_d   = CAUSE_BUS;
`endif
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_DECODE: begin
        ALUSrcB = SRCB_IMMSH;
        ALUOp   = alu_op_s;
        if (illegal_s) begin
          instr_done = 1'b1;
          state_d    = ST_ABORT;
`ifdef MCTRL_EXCEPTION_EN
          exc_d      = CAUSE_ILLEGAL;
`endif
        end else if (is_jump_s) begin
          PCWrite    = 1'b1;
          instr_done = 1'b1;
          state_d    = ST_FETCH;
          if (OpCode == OP_R) begin
            PCSrc    = PCSRC_RS;
            RegWrite = (Funct == FN_JALR);
            RegDst   = REGDST_RD;
            MemtoReg = (Funct == FN_JALR) ? WBSEL_PC : WBSEL_ALU;
          end else begin
            PCSrc    = PCSRC_JUMP;
            RegWrite = (OpCode == OP_JAL);
            RegDst   = (OpCode == OP_JAL) ? REGDST_RA : REGDST_RD;
            MemtoReg = (OpCode == OP_JAL) ? WBSEL_PC : WBSEL_ALU;
          end
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        ALUOp = alu_op_s;
        ExtOp = !((OpCode == OP_SLTIU) || (OpCode == OP_ANDI));
        LuOp  = (OpCode == OP_LUI);
        if (is_branch_s) begin
          ALUSrcA    = 1'b1;
          ALUSrcB    = SRCB_RT;
          PCSrc      = PCSRC_ALUOUT;
          PCWrite    = Zero;
          instr_done = 1'b1;
          state_d    = ST_FETCH;
        end else if (is_load_s || is_store_s) begin
          ALUSrcA = 1'b1;
          ALUSrcB = SRCB_IMM;
          state_d = ST_MEM;
        end else if (is_rtype_s) begin
          ALUSrcA = !is_shift_s;
          ALUSrcB = SRCB_RT;
          state_d = ST_WB;
        end else if (is_imm_s) begin
          ALUSrcA = 1'b1;
          ALUSrcB = SRCB_IMM;
          state_d = ST_WB;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_MEM: begin
        IorD     = 1'b1;
        MemRead  = is_load_s;
        MemWrite = is_store_s;
        if (mem_ready) begin
          instr_done = !is_load_s;
          state_d    = is_load_s ? ST_WB : ST_FETCH;
        end else if (timeout_s) begin
          bus_err = 1'b1;
          state_d = ST_ABORT;
`ifdef MCTRL_EXCEPTION_EN
          exc_d   = CAUSE_BUS;
`endif
        end else begin
          state_d = ST_MEM;
        end
      end
      ST_WB: begin
        RegWrite   = 1'b1;
        RegDst     = is_rtype_s ? REGDST_RD : REGDST_RT;
        MemtoReg   = is_load_s ? WBSEL_MDR : WBSEL_ALU;
        instr_done = 1'b1;
        state_d    = ST_FETCH;
      end
`ifdef MCTRL_EXCEPTION_EN
      ST_EXC: begin
        PCWrite = 1'b1;
        PCSrc   = PCSRC_ALUOUT;
        state_d = ST_FETCH;
      end
`endif
      default: state_d = ST_INIT;
    endcase
  end

  // Wait counter restarts on every state entry or abort; cycle counter
  // restarts on each new FETCH and saturates at its maximum
  always_comb begin
    wait_d = wait_q;
    cyc_d  = cyc_q;
    if ((state_d != state_q) || bus_err) begin
      wait_d = '0;
    end else if (!mem_ready && ((state_q == ST_FETCH) || (state_q == ST_MEM))) begin
      wait_d = wait_q + 1'b1;
    end else begin
      wait_d = wait_q;
    end
    if ((state_d == ST_FETCH) && (state_q != ST_FETCH)) begin
      cyc_d = {{(CNT_W-1){1'b0}}, 1'b1};
    end else if (cyc_q != CNT_MAX) begin
      cyc_d = cyc_q + 1'b1;
    end else begin
      cyc_d = cyc_q;
    end
  end

  // State and counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_INIT;
      wait_q  <= '0;
      cyc_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      cyc_q   <= cyc_d;
    end
  end

`ifdef MCTRL_EXCEPTION_EN
  // Exception cause holds until the next EXC entry
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      exc_q <= 2'b00;
    end else begin
      exc_q <= exc_d;
    end
  end
`endif

  assign state   = state_q;
  assign cyc_cnt = cyc_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control (MEM_TIMEOUT=4).
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] OpCode, Funct;
  logic       Zero, mem_ready;
  logic       PCWrite, IRWrite, IorD, MemRead, MemWrite, RegWrite;
  logic [1:0] RegDst, MemtoReg, ALUSrcB, PCSrc;
  logic       ALUSrcA, ExtOp, LuOp;
  logic [3:0] ALUOp;
  logic       instr_done, bus_err;
  logic [3:0] cyc_cnt;
  logic [2:0] state;
`ifdef MCTRL_EXCEPTION_EN
  logic [1:0] exc_cause;
`endif

  int checks = 0;
  int errors = 0;
  int done_seen = 0;

  always #5 clk = ~clk;

  multicycle_control #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .OpCode     (OpCode),
    .Funct      (Funct),
    .Zero       (Zero),
    .mem_ready  (mem_ready),
    .PCWrite    (PCWrite),
    .IRWrite    (IRWrite),
    .IorD       (IorD),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .RegWrite   (RegWrite),
    .RegDst     (RegDst),
    .MemtoReg   (MemtoReg),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .PCSrc      (PCSrc),
    .ExtOp      (ExtOp),
    .LuOp       (LuOp),
    .ALUOp      (ALUOp),
    .instr_done (instr_done),
    .bus_err    (bus_err),
    .cyc_cnt    (cyc_cnt),
`ifdef MCTRL_EXCEPTION_EN
    .exc_cause  (exc_cause),
`endif
    .state      (state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge, apply inputs, let outputs settle
  task automatic step(input logic rdy, input logic z);
    @(negedge clk);
    mem_ready = rdy;
    Zero      = z;
    #1;
    done_seen += int'(instr_done);
  endtask

  initial begin
    reset = 1'b1; OpCode = 6'h23; Funct = 6'h00; Zero = 1'b0; mem_ready = 1'b0;
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_cyc", 32'(cyc_cnt), 32'd0);
    chk("rst_memread", 32'(MemRead), 32'd0);
    chk("rst_pcwrite", 32'(PCWrite), 32'd0);
`ifdef MCTRL_EXCEPTION_EN
    chk("rst_exc", 32'(exc_cause), 32'd0);
`endif
    reset = 1'b1;

    // lw with 2 wait cycles in FETCH and MEM
    step(1'b0, 1'b0);
    chk("lw_f1_state", 32'(state), 32'd1);
    chk("lw_f1_cyc", 32'(cyc_cnt), 32'd1);
    chk("lw_f1_memread", 32'(MemRead), 32'd1);
    chk("lw_f1_irwrite", 32'(IRWrite), 32'd0);
    step(1'b0, 1'b0);
    chk("lw_f2_state", 32'(state), 32'd1);
    step(1'b1, 1'b0);
    chk("lw_f3_state", 32'(state), 32'd1);
    chk("lw_f3_irwrite", 32'(IRWrite), 32'd1);
    chk("lw_f3_pcwrite", 32'(PCWrite), 32'd1);
    chk("lw_f3_srcb", 32'(ALUSrcB), 32'd1);
    chk("lw_f3_aluop", 32'(ALUOp), 32'd0);
    step(1'b1, 1'b0);
    chk("lw_dec_state", 32'(state), 32'd2);
    chk("lw_dec_srcb", 32'(ALUSrcB), 32'd3);
    step(1'b1, 1'b0);
    chk("lw_ex_state", 32'(state), 32'd3);
    chk("lw_ex_srca", 32'(ALUSrcA), 32'd1);
    chk("lw_ex_srcb", 32'(ALUSrcB), 32'd2);
    chk("lw_ex_extop", 32'(ExtOp), 32'd1);
    chk("lw_ex_aluop", 32'(ALUOp), 32'd8);
    step(1'b0, 1'b0);
    chk("lw_m1_state", 32'(state), 32'd4);
    chk("lw_m1_iord", 32'(IorD), 32'd1);
    chk("lw_m1_memread", 32'(MemRead), 32'd1);
    step(1'b0, 1'b0);
    chk("lw_m2_state", 32'(state), 32'd4);
    step(1'b1, 1'b0);
    chk("lw_m3_state", 32'(state), 32'd4);
    chk("lw_m3_done", 32'(instr_done), 32'd0);
    step(1'b1, 1'b0);
    chk("lw_wb_state", 32'(state), 32'd5);
    chk("lw_wb_regwrite", 32'(RegWrite), 32'd1);
    chk("lw_wb_memtoreg", 32'(MemtoReg), 32'd1);
    chk("lw_wb_regdst", 32'(RegDst), 32'd1);
    chk("lw_wb_done", 32'(instr_done), 32'd1);
    chk("lw_wb_cyc", 32'(cyc_cnt), 32'd9);
    chk("lw_done_once", 32'(done_seen), 32'd1);

    // beq taken
    step(1'b1, 1'b1);
    chk("beq1_f_cyc", 32'(cyc_cnt), 32'd1);
    OpCode = 6'h04;
    step(1'b1, 1'b1);
    chk("beq1_dec_state", 32'(state), 32'd2);
    step(1'b1, 1'b1);
    chk("beq1_ex_state", 32'(state), 32'd3);
    chk("beq1_ex_pcwrite", 32'(PCWrite), 32'd1);
    chk("beq1_ex_pcsrc", 32'(PCSrc), 32'd3);
    chk("beq1_ex_aluop", 32'(ALUOp), 32'd1);
    chk("beq1_ex_done", 32'(instr_done), 32'd1);

    // beq not taken
    step(1'b1, 1'b0);
    chk("beq0_f_state", 32'(state), 32'd1);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    chk("beq0_ex_pcwrite", 32'(PCWrite), 32'd0);
    chk("beq0_ex_cyc", 32'(cyc_cnt), 32'd3);
    chk("beq0_ex_done", 32'(instr_done), 32'd1);

    // jal
    step(1'b1, 1'b0);
    OpCode = 6'h03;
    step(1'b1, 1'b0);
    chk("jal_dec_state", 32'(state), 32'd2);
    chk("jal_pcwrite", 32'(PCWrite), 32'd1);
    chk("jal_pcsrc", 32'(PCSrc), 32'd1);
    chk("jal_regwrite", 32'(RegWrite), 32'd1);
    chk("jal_regdst", 32'(RegDst), 32'd2);
    chk("jal_memtoreg", 32'(MemtoReg), 32'd2);
    chk("jal_done", 32'(instr_done), 32'd1);
    step(1'b1, 1'b0);
    chk("jal_next_state", 32'(state), 32'd1);

    // sll: shift uses shamt, ALUSrcA=0
    OpCode = 6'h00; Funct = 6'h00;
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    chk("sll_ex_srca", 32'(ALUSrcA), 32'd0);
    chk("sll_ex_aluop", 32'(ALUOp), 32'd2);
    step(1'b1, 1'b0);
    chk("sll_wb_regdst", 32'(RegDst), 32'd0);
    chk("sll_wb_regwrite", 32'(RegWrite), 32'd1);

    // andi: zero extend, AND class
    step(1'b1, 1'b0);
    OpCode = 6'h0c;
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    chk("andi_ex_extop", 32'(ExtOp), 32'd0);
    chk("andi_ex_aluop", 32'(ALUOp), 32'd4);
    chk("andi_ex_srcb", 32'(ALUSrcB), 32'd2);
    step(1'b1, 1'b0);
    chk("andi_wb_regdst", 32'(RegDst), 32'd1);

    // sw with memory stuck: timeout after 4 MEM cycles
    step(1'b1, 1'b0);
    OpCode = 6'h2b;
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    chk("sw_ex_state", 32'(state), 32'd3);
    step(1'b0, 1'b0);
    chk("sw_m1_memwrite", 32'(MemWrite), 32'd1);
    chk("sw_m1_buserr", 32'(bus_err), 32'd0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    chk("sw_m3_buserr", 32'(bus_err), 32'd0);
    step(1'b0, 1'b0);
    chk("sw_m4_state", 32'(state), 32'd4);
    chk("sw_m4_buserr", 32'(bus_err), 32'd1);
    chk("sw_m4_done", 32'(instr_done), 32'd0);
    step(1'b1, 1'b0);
    chk("sw_m5_buserr", 32'(bus_err), 32'd0);
`ifdef MCTRL_EXCEPTION_EN
    chk("sw_exc_state", 32'(state), 32'd6);
    chk("sw_exc_cause", 32'(exc_cause), 32'd2);
    chk("sw_exc_pcwrite", 32'(PCWrite), 32'd1);
    chk("sw_exc_pcsrc", 32'(PCSrc), 32'd3);
    step(1'b1, 1'b0);
`endif
    chk("sw_to_state", 32'(state), 32'd1);

    // illegal opcode retires as a NOP
    OpCode = 6'h3f;
    step(1'b1, 1'b0);
    chk("ill_dec_state", 32'(state), 32'd2);
    chk("ill_done", 32'(instr_done), 32'd1);
    chk("ill_regwrite", 32'(RegWrite), 32'd0);
    chk("ill_pcwrite", 32'(PCWrite), 32'd0);
    chk("ill_memwrite", 32'(MemWrite), 32'd0);
    step(1'b1, 1'b0);
`ifdef MCTRL_EXCEPTION_EN
    chk("ill_exc_state", 32'(state), 32'd6);
    chk("ill_exc_cause", 32'(exc_cause), 32'd1);
    step(1'b1, 1'b0);
`endif
    chk("ill_next_state", 32'(state), 32'd1);

    // reset asserted mid-MEM of sw
    OpCode = 6'h2b;
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    chk("rsw_m_memwrite", 32'(MemWrite), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("rsw_memwrite", 32'(MemWrite), 32'd0);
    chk("rsw_state", 32'(state), 32'd0);
    chk("rsw_cyc", 32'(cyc_cnt), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rsw_rel_state", 32'(state), 32'd0);
    step(1'b1, 1'b0);
    chk("rsw_fetch_state", 32'(state), 32'd1);
    chk("rsw_fetch_cyc", 32'(cyc_cnt), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
